// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 for the pipelined MIPS core.
// Holds SR, Cause, EPC and PRId. Samples the hardware interrupt lines,
// arbitrates them against the synchronous exception from M, and serves
// mfc0 / mtc0 / eret commands from the control decoder.
module cp0_ctrl #(
  parameter int          NUM_IRQ = 6,
  parameter logic [31:0] PRID    = 32'h4D49_5053
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] hw_int,
  input  logic [31:0]        pc,
  input  logic               bd,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [1:0]         wt_pr,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               int_req,
  output logic [31:0]        epc,
  output logic               exl
);

  // Coprocessor command encoding driven by the decoder.
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_MTC0 = 2'b01;
  localparam logic [1:0] CMD_MFC0 = 2'b10;
  localparam logic [1:0] CMD_ERET = 2'b11;

  // CP0 register numbers.
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Bit positions inside SR / Cause.
  localparam int IM_LSB  = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int EXC_LSB = 2;

  // Architectural state. Only implemented fields are stored; every other
  // bit of SR and Cause is hard-wired to zero on read. EPC keeps only its
  // word address because bits [1:0] are always zero.
  logic [NUM_IRQ-1:0] sr_im_q,     sr_im_d;
  logic               sr_exl_q,    sr_exl_d;
  logic               sr_ie_q,     sr_ie_d;
  logic               cause_bd_q,  cause_bd_d;
  logic [NUM_IRQ-1:0] cause_ip_q,  cause_ip_d;
  logic [4:0]         cause_exc_q, cause_exc_d;
  logic [29:0]        epc_q,       epc_d;

  // Pending terms and the take decision.
  logic irq_pend;
  logic exc_pend;
  logic take;
  logic is_mtc0;
  logic is_eret;
  logic [29:0] take_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Interrupts and exceptions are both masked while EXL is set, so a take
  // raises int_req for exactly one cycle. The reset cycle never takes.
  always_comb begin
    irq_pend = sr_ie_q & ~sr_exl_q & (|(cause_ip_q & sr_im_q));
    exc_pend = exc_req & ~sr_exl_q;
    take     = (irq_pend | exc_pend) & ~reset;
  end

  assign int_req = take;

  // A take suppresses the coprocessor command in M; it re-executes later.
  assign is_mtc0 = (wt_pr == CMD_MTC0) & ~take;
  assign is_eret = (wt_pr == CMD_ERET) & ~take;

  // Restart address: the branch itself when the faulting instruction sits
  // in a delay slot. Subtracting one word wraps naturally modulo 2^32.
  assign take_epc = pc[31:2] - {29'd0, bd};

  // Next-state logic for all CP0 fields.
  always_comb begin
    // NOTE: every variable gets a default first so always_comb infers no latch.
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    // IP follows the interrupt lines every cycle; it is not sticky.
    cause_ip_d  = hw_int;

    if (take) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd;
      epc_d       = take_epc;
      // Hardware interrupts win over a simultaneous synchronous exception.
      cause_exc_d = irq_pend ? 5'd0 : exc_code;
    end else if (is_mtc0) begin
      case (cp0_addr)
        ADDR_SR: begin
          sr_im_d  = wdata[IM_LSB +: NUM_IRQ];
          sr_exl_d = wdata[EXL_BIT];
          sr_ie_d  = wdata[IE_BIT];
        end
        ADDR_EPC: epc_d = wdata[31:2];
        // Cause, PRId and unmapped registers are read-only here.
        default: ;
      endcase
    end else if (is_eret) begin
      sr_exl_d = 1'b0;
    end
  end

  // State register with synchronous reset; the reset cycle writes nothing.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= 5'd0;
      epc_q       <= 30'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // Assemble the architectural views of SR and Cause.
  always_comb begin
    sr_val                     = 32'd0;
    sr_val[IM_LSB +: NUM_IRQ]  = sr_im_q;
    sr_val[EXL_BIT]            = sr_exl_q;
    sr_val[IE_BIT]             = sr_ie_q;

    cause_val                     = 32'd0;
    cause_val[BD_BIT]             = cause_bd_q;
    cause_val[IM_LSB +: NUM_IRQ]  = cause_ip_q;
    cause_val[EXC_LSB +: 5]       = cause_exc_q;
  end

  // mfc0 read port: zero unless an mfc0 targets a mapped register.
  always_comb begin
    rdata = 32'd0;
    if (wt_pr == CMD_MFC0) begin
      case (cp0_addr)
        ADDR_SR:    rdata = sr_val;
        ADDR_CAUSE: rdata = cause_val;
        ADDR_EPC:   rdata = {epc_q, 2'b00};
        ADDR_PRID:  rdata = PRID;
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign epc = {epc_q, 2'b00};
  assign exl = sr_exl_q;

  // Bits of the inputs that have no home in the implemented fields.
  logic unused_bits;
  assign unused_bits = ^{wdata, pc[1:0], CMD_NONE};

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed testbench for cp0_ctrl: linear stimulus, hand-computed expectations.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  hw_int;
  logic [31:0] pc;
  logic        bd;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [1:0]  wt_pr;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_req;
  logic [31:0] epc;
  logic        exl;

  int total = 0;
  int bad   = 0;

  cp0_ctrl #(.NUM_IRQ(6), .PRID(32'h4D49_5053)) dut (
    .clk      (clk),
    .reset    (reset),
    .hw_int   (hw_int),
    .pc       (pc),
    .bd       (bd),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .wt_pr    (wt_pr),
    .cp0_addr (cp0_addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .int_req  (int_req),
    .epc      (epc),
    .exl      (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational mfc0 read; leaves the command at none afterwards.
  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    wt_pr    = 2'b10;
    cp0_addr = a;
    #1;
    v = rdata;
    wt_pr = 2'b00;
    #1;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; hw_int = 6'h3F; pc = 32'd0; bd = 1'b0;
    exc_req = 1'b0; exc_code = 5'd0; wt_pr = 2'b00; cp0_addr = 5'd0; wdata = 32'd0;
    tick(); tick();

    // Reset state: everything zero, interrupts masked.
    rd(5'd12, v); check("rst_sr", v, 32'd0);
    rd(5'd13, v); check("rst_cause", v, 32'd0);
    rd(5'd14, v); check("rst_epc_rd", v, 32'd0);
    rd(5'd5,  v); check("rst_unmapped", v, 32'd0);
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_exl", 32'(exl), 32'd0);
    check("rst_epc", epc, 32'd0);

    // Leave reset with all lines high: IP loads, SR=0 still masks.
    reset = 1'b0;
    tick();
    check("masked_int_req", 32'(int_req), 32'd0);
    rd(5'd13, v); check("ip_follows", v, 32'h0000_FC00);

    // mtc0 SR = IM0|IE, drop the lines in the same cycle.
    hw_int = 6'h00; wt_pr = 2'b01; cp0_addr = 5'd12; wdata = 32'h0000_0401;
    tick();
    wt_pr = 2'b00;
    rd(5'd12, v); check("sr_written", v, 32'h0000_0401);
    check("idle_int_req", 32'(int_req), 32'd0);

    // Raise hw_int[0]: seen one edge later.
    hw_int = 6'h01; pc = 32'h0000_3010; bd = 1'b0;
    #1;
    check("irq_lat0", 32'(int_req), 32'd0);
    tick();
    check("irq_lat1", 32'(int_req), 32'd1);
    tick();  // take
    check("take1_epc", epc, 32'h0000_3010);
    check("take1_exl", 32'(exl), 32'd1);
    check("take1_int_req", 32'(int_req), 32'd0);
    rd(5'd13, v); check("take1_cause", v, 32'h0000_0400);

    // eret, then take from a delay slot.
    wt_pr = 2'b11;
    tick();
    wt_pr = 2'b00; bd = 1'b1; pc = 32'h0000_3024;
    #1;
    check("eret1_exl", 32'(exl), 32'd0);
    check("eret1_int_req", 32'(int_req), 32'd1);
    tick();
    check("take_bd_epc", epc, 32'h0000_3020);
    rd(5'd13, v); check("take_bd_cause", v, 32'h8000_0400);

    // Delay-slot take at pc=0 wraps.
    wt_pr = 2'b11;
    tick();
    wt_pr = 2'b00; pc = 32'd0; bd = 1'b1;
    tick();
    check("wrap_epc", epc, 32'hFFFF_FFFC);

    // Synchronous exception with no interrupt pending.
    hw_int = 6'h00; wt_pr = 2'b11;
    tick();
    wt_pr = 2'b00; bd = 1'b0; pc = 32'h0000_3100;
    #1;
    check("no_irq_int_req", 32'(int_req), 32'd0);
    exc_req = 1'b1; exc_code = 5'd10;
    #1;
    check("exc_immediate", 32'(int_req), 32'd1);
    tick();
    exc_req = 1'b0;
    rd(5'd13, v); check("exc_cause", v, 32'h0000_0028);
    check("exc_epc", epc, 32'h0000_3100);

    // Exception together with an enabled interrupt: interrupt wins.
    hw_int = 6'h01; wt_pr = 2'b11;
    tick();
    wt_pr = 2'b00; exc_req = 1'b1; exc_code = 5'd10; pc = 32'h0000_3200;
    tick();
    exc_req = 1'b0;
    rd(5'd13, v); check("prio_cause", v, 32'h0000_0400);
    check("prio_epc", epc, 32'h0000_3200);

    // eret with the line still high re-asserts int_req immediately.
    wt_pr = 2'b11;
    tick();
    wt_pr = 2'b00;
    #1;
    check("eret2_exl", 32'(exl), 32'd0);
    check("eret2_int_req", 32'(int_req), 32'd1);

    // mtc0 EPC in the same cycle as a take is dropped.
    wt_pr = 2'b01; cp0_addr = 5'd14; wdata = 32'h0000_3007; pc = 32'h0000_3300;
    tick();
    check("mtc0_drop_epc", epc, 32'h0000_3300);

    // Same write with no take goes through, low bits cleared.
    tick();
    wt_pr = 2'b00;
    rd(5'd14, v); check("mtc0_epc_rd", v, 32'h0000_3004);
    check("mtc0_epc_out", epc, 32'h0000_3004);

    // Writes to Cause are ignored.
    wt_pr = 2'b01; cp0_addr = 5'd13; wdata = 32'hFFFF_FFFF;
    tick();
    wt_pr = 2'b00;
    rd(5'd13, v); check("cause_ro", v, 32'h0000_0400);

    // Clearing SR (IE and EXL) keeps the pending line masked.
    wt_pr = 2'b01; cp0_addr = 5'd12; wdata = 32'd0;
    tick();
    wt_pr = 2'b00;
    #1;
    check("sr_clr_exl", 32'(exl), 32'd0);
    check("sr_clr_int_req", 32'(int_req), 32'd0);

    // PRId, and no read data without an mfc0 command.
    rd(5'd15, v); check("prid", v, 32'h4D49_5053);
    cp0_addr = 5'd15; wt_pr = 2'b00;
    #1;
    check("no_cmd_rdata", rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
